fact_seq_engine: RTL

- Parametrised, multi-cycle factorial engine replacing the elaboration-time factorial function with a run-time block.
- Accepts an operand on a start pulse, iterates one multiply per clock, then reports the result with a done pulse and an overflow flag.
- Sits behind board switch/LED glue or any register-mapped controller; single clock domain.

---
 rtl/fact_seq_if.sv | 11 +
 rtl/fact_seq_engine.sv | 63 ++++++
 2 files changed

// File: rtl/fact_seq_if.sv
// fact_seq_if: start/operand request and busy/done/result/overflow status of the factorial engine
interface fact_seq_if #(parameter int OP_W = 4, parameter int RES_W = 32);
  logic start;
  logic [OP_W-1:0] operand;
  logic busy;
  logic done;
  logic [RES_W-1:0] result;
  logic overflow;
  modport master(output start, operand, input busy, done, result, overflow);
  modport slave(input start, operand, output busy, done, result, overflow);
endinterface

// File: rtl/fact_seq_engine.sv
// fact_seq_engine: run-time n! engine, one multiply per clock, sticky overflow flag.
// Define FACT_SATURATE_EN to report all ones instead of the wrapped value when overflow is set.
module fact_seq_engine #(
  parameter int OP_W = 4,
  parameter int RES_W = 32
) (
  input logic clk,
  input logic rst,
  fact_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [RES_W-1:0] acc, result, res_nx;
  logic [OP_W:0] idx;
  logic [OP_W-1:0] n;
  logic [RES_W+OP_W-1:0] p;
  logic overflow, ovf_nx, done, last;
  // idx never exceeds n while in CALC, so its low OP_W bits carry the whole multiplier
  assign p = {{OP_W{1'b0}}, acc} * {{RES_W{1'b0}}, idx[OP_W-1:0]};
  assign ovf_nx = overflow | (|p[RES_W+OP_W-1:RES_W]);
  assign last = idx == {1'b0, n};
`ifdef FACT_SATURATE_EN
  assign res_nx = state == IDLE ? RES_W'(1) : ovf_nx ? '1 : p[RES_W-1:0];
`else
  assign res_nx = state == IDLE ? RES_W'(1) : p[RES_W-1:0];
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (bus.start ? (bus.operand < OP_W'(2) ? DONE : CALC) : IDLE)
             : state == CALC ? (last ? DONE : CALC)
             : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      acc <= '0;
      idx <= '0;
      n <= '0;
      overflow <= 1'b0;
      result <= '0;
      done <= 1'b0;
    end else begin
      done <= state_nx == DONE;
      if (state == IDLE && bus.start) begin
        n <= bus.operand;
        acc <= RES_W'(1);
        idx <= (OP_W+1)'(2);
        overflow <= 1'b0;
      end
      if (state == CALC) begin
        acc <= p[RES_W-1:0];
        overflow <= ovf_nx;
        idx <= idx + 1'b1;
      end
      if (state_nx == DONE) result <= res_nx;
    end
  assign bus.busy = state != IDLE;
  assign bus.done = done;
  assign bus.result = result;
  assign bus.overflow = overflow;
endmodule
